asg_signal_capture: RTL and testbench

//  Receive-side counterpart of the azimuth signal generator: after each radar

---
 rtl/asg_signal_capture.sv | 200 ++++++++++++++++++++
 tb/tb_asg_signal_capture.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asg_signal_capture.sv
// asg_signal_capture
//   Receive-side capture for the azimuth signal generator. After each radar
//   trigger, SIG_IN is sampled on every microsecond strobe into a SIZE-bit
//   frame, where bit 0 holds the first sample. A completed or truncated frame
//   is published together with its rising-edge count through a valid/ack
//   handshake.
//
// Ports
//   SYS_CLK     in   1      system clock
//   SYS_RST     in   1      synchronous reset, active-high
//   EN          in   1      capture enable; dropping it mid-capture aborts
//   TRIG        in   1      radar trigger pulse, starts/restarts a capture
//   USEC_PE     in   1      microsecond strobe, one sample per pulse
//   SIG_IN      in   1      serial signal, already in the SYS_CLK domain
//   DATA        out  SIZE   last published frame
//   PULSE_CNT   out  CNT_W  rising edges in the published frame (saturating)
//   TRUNC       out  1      published frame was cut short by a trigger
//   DATA_VALID  out  1      published outputs valid, held until DATA_ACK
//   DATA_ACK    in   1      consumer accepts the frame
//   OVERRUN     out  1      sticky: a frame was dropped
//   BUSY        out  1      capture in progress
//
// States
//   state      | meaning
//   ST_IDLE    | waiting for TRIG with EN high
//   ST_CAPTURE | sampling SIG_IN on each USEC_PE into the shadow frame
module asg_signal_capture #(
  parameter int SIZE  = 3200,
  parameter int CNT_W = 16
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic             EN,
  input  logic             TRIG,
  input  logic             USEC_PE,
  input  logic             SIG_IN,
  output logic [SIZE-1:0]  DATA,
  output logic [CNT_W-1:0] PULSE_CNT,
  output logic             TRUNC,
  output logic             DATA_VALID,
  input  logic             DATA_ACK,
  output logic             OVERRUN,
  output logic             BUSY
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_e;

  localparam int               IDX_W    = $clog2(SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SIZE-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prev_q, prev_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic              trunc_q, trunc_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic              start, abort, smp, pub, pub_trunc;
  logic [SIZE-1:0]   shadow_smp;
  logic [CNT_W-1:0]  cnt_smp;
  logic [SIZE-1:0]   pub_data;
  logic [CNT_W-1:0]  pub_cnt;

  // State and datapath registers
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      data_q   <= '0;
      pcnt_q   <= '0;
      trunc_q  <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      data_q   <= data_d;
      pcnt_q   <= pcnt_d;
      trunc_q  <= trunc_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  // Next state. EN low aborts even if TRIG coincides; TRIG beats a
  // coincident strobe, so that strobe is never sampled.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    abort     = 1'b0;
    smp       = 1'b0;
    pub       = 1'b0;
    pub_trunc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (TRIG && EN) begin
          start   = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!EN) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (TRIG) begin
          pub       = 1'b1;
          pub_trunc = 1'b1;
          start     = 1'b1;
        end else if (USEC_PE) begin
          smp = 1'b1;
          if (idx_q == IDX_LAST) begin
            pub     = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture datapath and output registers
  always_comb begin
    // Frame and count including this cycle's sample, so a completing strobe
    // publishes in the same edge and DATA_VALID rises one cycle later.
    shadow_smp         = shadow_q;
    shadow_smp[idx_q]  = SIG_IN;
    cnt_smp            = cnt_q;
    if (SIG_IN && !prev_q && (cnt_q != CNT_MAX)) begin
      cnt_smp = cnt_q + CNT_ONE;
    end

    pub_data = pub_trunc ? shadow_q : shadow_smp;
    pub_cnt  = pub_trunc ? cnt_q    : cnt_smp;

    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    if (start || abort) begin
      shadow_d = '0;
      idx_d    = '0;
      cnt_d    = '0;
      prev_d   = 1'b0;
    end else if (smp) begin
      shadow_d = shadow_smp;
      cnt_d    = cnt_smp;
      prev_d   = SIG_IN;
      if (idx_q != IDX_LAST) begin
        idx_d = idx_q + IDX_ONE;
      end
    end

    data_d  = data_q;
    pcnt_d  = pcnt_q;
    trunc_d = trunc_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (pub) begin
      if (valid_q && !DATA_ACK) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = pub_data;
        pcnt_d  = pub_cnt;
        trunc_d = pub_trunc;
        valid_d = 1'b1;
      end
    end else if (valid_q && DATA_ACK) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d == ST_CAPTURE);
  end

  assign DATA       = data_q;
  assign PULSE_CNT  = pcnt_q;
  assign TRUNC      = trunc_q;
  assign DATA_VALID = valid_q;
  assign OVERRUN    = ovr_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_asg_signal_capture.sv
module tb_asg_signal_capture;

  localparam int SZ   = 16;
  localparam int BIGN = 3200;

  logic SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  logic rst, en, trig, usec, sig, ack;

  logic [SZ-1:0]   a_data;
  logic [15:0]     a_cnt;
  logic            a_trunc, a_valid, a_ovr, a_busy;
  logic [SZ-1:0]   b_data;
  logic [1:0]      b_cnt;
  logic            b_trunc, b_valid, b_ovr, b_busy;
  logic [BIGN-1:0] c_data;
  logic [15:0]     c_cnt;
  logic            c_trunc, c_valid, c_ovr, c_busy;

  asg_signal_capture #(.SIZE(SZ), .CNT_W(16)) u_a (
    .SYS_CLK(SYS_CLK), .SYS_RST(rst), .EN(en), .TRIG(trig), .USEC_PE(usec),
    .SIG_IN(sig), .DATA(a_data), .PULSE_CNT(a_cnt), .TRUNC(a_trunc),
    .DATA_VALID(a_valid), .DATA_ACK(ack), .OVERRUN(a_ovr), .BUSY(a_busy));

  asg_signal_capture #(.SIZE(SZ), .CNT_W(2)) u_b (
    .SYS_CLK(SYS_CLK), .SYS_RST(rst), .EN(en), .TRIG(trig), .USEC_PE(usec),
    .SIG_IN(sig), .DATA(b_data), .PULSE_CNT(b_cnt), .TRUNC(b_trunc),
    .DATA_VALID(b_valid), .DATA_ACK(ack), .OVERRUN(b_ovr), .BUSY(b_busy));

  asg_signal_capture #(.SIZE(BIGN), .CNT_W(16)) u_c (
    .SYS_CLK(SYS_CLK), .SYS_RST(rst), .EN(en), .TRIG(trig), .USEC_PE(usec),
    .SIG_IN(sig), .DATA(c_data), .PULSE_CNT(c_cnt), .TRUNC(c_trunc),
    .DATA_VALID(c_valid), .DATA_ACK(ack), .OVERRUN(c_ovr), .BUSY(c_busy));

  int checks = 0;
  int errors = 0;

  // Reference model for the SIZE=16 instances: a frame is the list of
  // samples taken since the trigger; it is turned into bits and an edge count
  // only when it is published.
  bit          m_cap;
  bit          m_q[$];
  bit          m_valid, m_trunc, m_ovr;
  logic [15:0] m_data;
  int          m_raw;

  task automatic model_step();
    bit          pub = 0;
    bit          ptr = 0;
    logic [15:0] pf = '0;
    int          pe = 0;
    bit          pv = 0;
    if (rst) begin
      m_cap = 0; m_q.delete(); m_valid = 0; m_trunc = 0; m_ovr = 0;
      m_data = '0; m_raw = 0;
      return;
    end
    if (m_cap) begin
      if (!en) begin
        m_cap = 0;
        m_q.delete();
      end else if (trig) begin
        pub = 1; ptr = 1;
      end else if (usec) begin
        m_q.push_back(sig);
        if (m_q.size() == SZ) begin
          pub = 1; ptr = 0; m_cap = 0;
        end
      end
    end else if (trig && en) begin
      m_cap = 1;
      m_q.delete();
    end
    if (pub) begin
      for (int i = 0; i < m_q.size(); i++) begin
        pf[i] = m_q[i];
        if (m_q[i] && !pv) pe++;
        pv = m_q[i];
      end
      m_q.delete();
      if (m_valid && !ack) m_ovr = 1;
      else begin
        m_data = pf; m_raw = pe; m_trunc = ptr; m_valid = 1;
      end
    end else if (m_valid && ack) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    model_step();
    #1;
  endtask

  task automatic strobe(input logic s);
    sig = s; usec = 1'b1; tick();
    usec = 1'b0; tick();
  endtask

  task automatic do_reset();
    en = 0; trig = 0; usec = 0; sig = 0; ack = 0;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
  endtask

  task automatic start_capture();
    en = 1'b1; trig = 1'b1; tick();
    trig = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_data, a_cnt, a_trunc, a_valid, a_ovr, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs: got %h want 0",
               {a_data, a_cnt, a_trunc, a_valid, a_ovr, a_busy});
    end
    checks++;
    if ({c_cnt, c_trunc, c_valid, c_ovr, c_busy} !== '0 || c_data !== '0) begin
      errors++;
      $display("FAIL reset_c_outputs: got cnt=%h flags=%b data_ones=%0d want all 0",
               c_cnt, {c_trunc, c_valid, c_ovr, c_busy}, $countones(c_data));
    end
    start_capture();
    for (int i = 0; i < 5; i++) strobe(1'b1);
    rst = 1'b1; tick(); tick(); tick();
    checks++;
    if ({a_data, a_cnt, a_trunc, a_valid, a_ovr, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_capture: got %h want 0",
               {a_data, a_cnt, a_trunc, a_valid, a_ovr, a_busy});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) strobe(1'b1);
    checks++;
    if ({a_valid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_publish: got valid/busy=%b want 00", {a_valid, a_busy});
    end
  endtask

  task automatic test_loopback();
    logic [BIGN-1:0] exp_c = '0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 3; j++) exp_c[300 + 400*k + j] = 1'b1;
    do_reset();
    start_capture();
    for (int i = 0; i < BIGN - 1; i++) strobe(exp_c[i]);
    checks++;
    if ({c_busy, c_valid} !== 2'b10) begin
      errors++;
      $display("FAIL loop_before_last: got busy/valid=%b want 10", {c_busy, c_valid});
    end
    sig = exp_c[BIGN-1]; usec = 1'b1; tick();
    checks++;
    if (c_valid !== 1'b1) begin
      errors++;
      $display("FAIL loop_latency: got valid=%b want 1", c_valid);
    end
    usec = 1'b0; tick();
    checks++;
    if (c_data !== exp_c) begin
      errors++;
      $display("FAIL loop_data: got %0d differing bits want 0", $countones(c_data ^ exp_c));
    end
    checks++;
    if (c_cnt !== 16'd8 || c_trunc !== 1'b0 || c_busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_cnt_trunc: got cnt=%0d trunc=%b busy=%b want 8 0 0",
               c_cnt, c_trunc, c_busy);
    end
  endtask

  task automatic test_early_trig();
    do_reset();
    start_capture();
    for (int i = 0; i < 5; i++) strobe(1'b1);
    trig = 1'b1; tick(); trig = 1'b0;
    checks++;
    if (a_data !== 16'h001F || a_cnt !== 16'd1 || a_trunc !== 1'b1 || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL early_frame: got data=%h cnt=%0d trunc=%b valid=%b want 001f 1 1 1",
               a_data, a_cnt, a_trunc, a_valid);
    end
    tick();
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL early_busy: got %b want 1", a_busy);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_ack_clear: got valid=%b want 0", a_valid);
    end
  endtask

  task automatic run_frame(input logic [SZ-1:0] pat);
    start_capture();
    for (int i = 0; i < SZ; i++) strobe(pat[i]);
  endtask

  task automatic test_overrun();
    logic [SZ-1:0] pc = 16'h8001;
    do_reset();
    run_frame(16'hA5C3);
    checks++;
    if (a_data !== 16'hA5C3 || a_valid !== 1'b1 || a_ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got data=%h valid=%b ovr=%b want a5c3 1 0",
               a_data, a_valid, a_ovr);
    end
    run_frame(16'h0FF0);
    checks++;
    if (a_data !== 16'hA5C3 || a_valid !== 1'b1 || a_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: got data=%h valid=%b ovr=%b want a5c3 1 1",
               a_data, a_valid, a_ovr);
    end
    start_capture();
    for (int i = 0; i < SZ - 1; i++) strobe(pc[i]);
    sig = pc[SZ-1]; usec = 1'b1; ack = 1'b1; tick();
    usec = 1'b0; ack = 1'b0; tick();
    checks++;
    if (a_data !== 16'h8001 || a_cnt !== 16'd2 || a_valid !== 1'b1 || a_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_third_ack: got data=%h cnt=%0d valid=%b ovr=%b want 8001 2 1 1",
               a_data, a_cnt, a_valid, a_ovr);
    end
  endtask

  task automatic test_coincidence();
    logic [SZ-1:0] p = 16'h00F0;
    do_reset();
    en = 1'b1; sig = 1'b1; trig = 1'b1; usec = 1'b1; tick();
    trig = 1'b0; usec = 1'b0; tick();
    for (int i = 0; i < SZ - 1; i++) strobe(p[i]);
    checks++;
    if ({a_busy, a_valid} !== 2'b10) begin
      errors++;
      $display("FAIL coin_not_done: got busy/valid=%b want 10", {a_busy, a_valid});
    end
    strobe(p[SZ-1]);
    checks++;
    if (a_data !== 16'h00F0 || a_cnt !== 16'd1 || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL coin_frame: got data=%h cnt=%0d valid=%b want 00f0 1 1",
               a_data, a_cnt, a_valid);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    do_reset();
    start_capture();
    for (int i = 0; i < 4; i++) strobe(1'b1);
    en = 1'b0; tick();
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b want 0", a_busy);
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      strobe(1'b1);
      if (a_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_publish: got %0d cycles with valid want 0", seen);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    start_capture();
    for (int i = 0; i < SZ; i++) strobe((i % 2) == 0);
    checks++;
    if (b_cnt !== 2'd3 || b_data !== 16'h5555 || b_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_cntw2: got cnt=%0d data=%h valid=%b want 3 5555 1",
               b_cnt, b_data, b_valid);
    end
    checks++;
    if (a_cnt !== 16'd8) begin
      errors++;
      $display("FAIL sat_cntw16: got cnt=%0d want 8", a_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] ea;
    logic [1:0]  eb;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      en   = ($urandom_range(0, 199) != 0);
      trig = en && ($urandom_range(0, 59) == 0);
      usec = ($urandom_range(0, 1) == 0);
      sig  = $urandom_range(0, 1);
      ack  = ($urandom_range(0, 3) == 0);
      tick();
      ea = 16'(m_raw > 65535 ? 65535 : m_raw);
      eb = 2'(m_raw > 3 ? 3 : m_raw);
      checks++;
      if (a_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, a_valid, m_valid);
      end
      checks++;
      if (a_data !== m_data) begin
        errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, a_data, m_data);
      end
      checks++;
      if (a_cnt !== ea || b_cnt !== eb) begin
        errors++;
        $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", n, a_cnt, b_cnt, ea, eb);
      end
      checks++;
      if (a_trunc !== m_trunc || a_ovr !== m_ovr || a_busy !== m_cap) begin
        errors++;
        $display("FAIL rnd_flags@%0d: got trunc/ovr/busy=%b%b%b want %b%b%b", n,
                 a_trunc, a_ovr, a_busy, m_trunc, m_ovr, m_cap);
      end
      checks++;
      if ({b_valid, b_data, b_trunc, b_ovr, b_busy} !==
          {m_valid, m_data, m_trunc, m_ovr, m_cap}) begin
        errors++;
        $display("FAIL rnd_b@%0d: got %h want %h", n,
                 {b_valid, b_data, b_trunc, b_ovr, b_busy},
                 {m_valid, m_data, m_trunc, m_ovr, m_cap});
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; trig = 1'b0; usec = 1'b0; sig = 1'b0; ack = 1'b0;
    test_reset();
    test_loopback();
    test_early_trig();
    test_overrun();
    test_coincidence();
    test_abort();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
